// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing one combinational ALU between the execute stage (req 0)
// and the address/aux unit (req 1). Build with ALU_SHARE_ARB_STATS_EN to add grant/conflict counters.
module alu_share_arb #(
  parameter int XLEN = 32
`ifdef ALU_SHARE_ARB_STATS_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [4:0]      req0_exe_fun,
  input  logic [4:0]      req1_exe_fun,
  input  logic [XLEN-1:0] req0_pc,
  input  logic [XLEN-1:0] req1_pc,
  input  logic [XLEN-1:0] req0_op1,
  input  logic [XLEN-1:0] req1_op1,
  input  logic [XLEN-1:0] req0_op2,
  input  logic [XLEN-1:0] req1_op2,
  output logic [4:0]      alu_exe_fun,
  output logic [XLEN-1:0] alu_pc,
  output logic [XLEN-1:0] alu_op1,
  output logic [XLEN-1:0] alu_op2,
  input  logic [XLEN-1:0] alu_out,
  input  logic            alu_br_flg,
  input  logic            alu_jump,
  output logic [1:0]      rsp_valid,
  input  logic [1:0]      rsp_ready,
  output logic [XLEN-1:0] rsp0_out,
  output logic [XLEN-1:0] rsp1_out,
  output logic            rsp0_br_flg,
  output logic            rsp1_br_flg,
  output logic            rsp0_jump,
  output logic            rsp1_jump
`ifdef ALU_SHARE_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1,
  output logic [CNT_W-1:0] conflict_cnt
`endif
);

  logic [1:0]      elig;
  logic [1:0]      grant;
  logic            rr_ptr;
  logic [XLEN-1:0] out_q [2];
  logic [1:0]      br_q;
  logic [1:0]      jump_q;

  // A slot may accept a new result only if empty or being drained this cycle.
  always_comb begin
    elig  = req_valid & (~rsp_valid | rsp_ready);
    grant = '0;
    if (rst_n) begin
      if (&elig) begin
        grant = rr_ptr ? 2'b10 : 2'b01;
      end else begin
        grant = elig;
      end
    end
  end

  assign req_ready = grant;

  always_comb begin
    alu_exe_fun = '0;
    alu_pc      = '0;
    alu_op1     = '0;
    alu_op2     = '0;
    if (grant[0]) begin
      alu_exe_fun = req0_exe_fun;
      alu_pc      = req0_pc;
      alu_op1     = req0_op1;
      alu_op2     = req0_op2;
    end else if (grant[1]) begin
      alu_exe_fun = req1_exe_fun;
      alu_pc      = req1_pc;
      alu_op1     = req1_op1;
      alu_op2     = req1_op2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= 1'b0;
      rsp_valid <= '0;
      br_q      <= '0;
      jump_q    <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        out_q[i] <= '0;
      end
    end else begin
      // Pointer moves to the requester that was not just served.
      if (|grant) begin
        rr_ptr <= grant[0];
      end
      for (int unsigned i = 0; i < 2; i++) begin
        if (grant[i]) begin
          rsp_valid[i] <= 1'b1;
          out_q[i]     <= alu_out;
          br_q[i]      <= alu_br_flg;
          jump_q[i]    <= alu_jump;
        end else if (rsp_ready[i]) begin
          rsp_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign rsp0_out    = out_q[0];
  assign rsp1_out    = out_q[1];
  assign rsp0_br_flg = br_q[0];
  assign rsp1_br_flg = br_q[1];
  assign rsp0_jump   = jump_q[0];
  assign rsp1_jump   = jump_q[1];

`ifdef ALU_SHARE_ARB_STATS_EN
  logic conflict;

  assign conflict = (&req_valid) && !(&grant);

  // Counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0   <= '0;
      grant_cnt1   <= '0;
      conflict_cnt <= '0;
    end else begin
      if (grant[0] && !(&grant_cnt0)) begin
        grant_cnt0 <= grant_cnt0 + CNT_W'(1);
      end
      if (grant[1] && !(&grant_cnt1)) begin
        grant_cnt1 <= grant_cnt1 + CNT_W'(1);
      end
      if (conflict && !(&conflict_cnt)) begin
        conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule
